mo_scan_sequencer: RTL and testbench

Upstream feeder of the motion-object vertical match stage. Once per scanline it walks the motion-object RAM, fetching 4 bytes per object. It assembles the 16-bit SR word ({Y, picture}) and drives the CK1 evaluation phase so the vertical stage can compute MATCHn and the picture-row address. It also presents the object's X and colour bytes to the horizontal stage.

---
 rtl/mo_scan_sequencer.sv | 146 ++++++++++++++
 tb/tb_mo_scan_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mo_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mo_scan_sequencer
// Purpose  : Per-scanline motion-object RAM walker feeding the vertical match
//            stage. Optional MO_SKIP_EMPTY_EN drops EVAL/EMIT for Y==0 objects.
// Revision : 1.0
// ============================================================================
module mo_scan_sequencer #(
    parameter int NUM_OBJ = 40,
    parameter int IDX_W   = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce2Hd5,
    input  logic                 line_start,
    input  logic                 bank,
    output logic [IDX_W+2:0]     ram_addr,
    input  logic [7:0]           ram_data,
    output logic [15:0]          SR,
    output logic                 CK1,
    output logic [7:0]           XPOS,
    output logic [7:0]           COLOR,
    output logic [IDX_W-1:0]     obj_idx,
    output logic                 busy,
    output logic                 done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_F0   = 3'd1,
        S_F1   = 3'd2,
        S_F2   = 3'd3,
        S_F3   = 3'd4,
        S_F4   = 3'd5,
        S_EVAL = 3'd6,
        S_EMIT = 3'd7
    } state_e;

    state_e             state_q;
    logic               bank_l_q;
    logic [IDX_W-1:0]   idx_q;
    logic [1:0]         byte_q;
    logic [15:0]        sr_q;
    logic [7:0]         xpos_q;
    logic [7:0]         color_q;
    logic               ck1_q;
    logic               busy_q;
    logic               done_q;

    logic               empty_d;
    logic               advance_d;
    logic               last_d;

`ifdef MO_SKIP_EMPTY_EN
    assign empty_d = (sr_q[15:8] == 8'h00);
`else
    assign empty_d = 1'b0;
`endif

    // An object is finished either at EMIT or, when empty, straight out of F4.
    assign advance_d = (state_q == S_EMIT) || ((state_q == S_F4) && empty_d);
    assign last_d    = (idx_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            bank_l_q <= 1'b0;
            idx_q    <= '0;
            byte_q   <= 2'd0;
            sr_q     <= 16'h0000;
            xpos_q   <= 8'h00;
            color_q  <= 8'h00;
            ck1_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (ce2Hd5) begin
            done_q <= 1'b0;
            ck1_q  <= 1'b0;
            if (line_start) begin
                // Start or abort-restart: the new scan always wins.
                bank_l_q <= bank;
                idx_q    <= '0;
                byte_q   <= 2'd0;
                busy_q   <= 1'b1;
                state_q  <= S_F0;
            end else begin
                case (state_q)
                    S_F0: begin
                        byte_q  <= 2'd1;
                        state_q <= S_F1;
                    end
                    S_F1: begin
                        sr_q[15:8] <= ram_data;
                        byte_q     <= 2'd2;
                        state_q    <= S_F2;
                    end
                    S_F2: begin
                        sr_q[7:0] <= ram_data;
                        byte_q    <= 2'd3;
                        state_q   <= S_F3;
                    end
                    S_F3: begin
                        xpos_q  <= ram_data;
                        state_q <= S_F4;
                    end
                    S_F4: begin
                        color_q <= ram_data;
                        ck1_q   <= 1'b1;
                        state_q <= S_EVAL;
                    end
                    S_EVAL: begin
                        state_q <= S_EMIT;
                    end
                    default: begin
                    end
                endcase

                if (advance_d) begin
                    ck1_q <= 1'b0;
                    if (last_d) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        byte_q  <= 2'd0;
                        state_q <= S_F0;
                    end
                end
            end
        end
    end

    assign ram_addr = {bank_l_q, idx_q, byte_q};
    assign SR       = sr_q;
    assign CK1      = ck1_q;
    assign XPOS     = xpos_q;
    assign COLOR    = color_q;
    assign obj_idx  = idx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mo_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mo_scan_sequencer
// Purpose  : Directed table, corner sequences and randomized run against a
//            per-object timeline model of mo_scan_sequencer.
// Revision : 1.0
// ============================================================================
module tb_mo_scan_sequencer;

    localparam int NOBJ = 40;
    localparam int IW   = 6;

    logic            clk;
    logic            reset;
    logic            ce2Hd5;
    logic            line_start;
    logic            bank;
    logic [IW+2:0]   ram_addr;
    logic [7:0]      ram_data;
    logic [15:0]     SR;
    logic            CK1;
    logic [7:0]      XPOS;
    logic [7:0]      COLOR;
    logic [IW-1:0]   obj_idx;
    logic            busy;
    logic            done;

    mo_scan_sequencer #(.NUM_OBJ(NOBJ), .IDX_W(IW)) dut (
        .clk        (clk),
        .reset      (reset),
        .ce2Hd5     (ce2Hd5),
        .line_start (line_start),
        .bank       (bank),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .SR         (SR),
        .CK1        (CK1),
        .XPOS       (XPOS),
        .COLOR      (COLOR),
        .obj_idx    (obj_idx),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read object RAM, advancing with the same clock enable.
    logic [7:0] mem [512];
    always @(posedge clk) if (ce2Hd5) ram_data <= mem[ram_addr];

    typedef struct packed {
        logic [IW+2:0] addr;
        logic [15:0]   sr;
        logic          ck1;
        logic [7:0]    x;
        logic [7:0]    c;
        logic [IW-1:0] idx;
        logic          busy;
        logic          done;
    } snap_t;

    typedef struct {
        logic  ce;
        logic  ls;
        logic  bk;
        snap_t e;
    } vec_t;

    int    vectors;
    int    miscompares;
    snap_t exp_s;
    snap_t q[$];
    vec_t  tbl[13];

    function automatic snap_t mk(input logic [IW+2:0] a, input logic [15:0] s, input logic k,
                                 input logic [7:0] x, input logic [7:0] c, input logic [IW-1:0] i,
                                 input logic b, input logic d);
        snap_t r;
        r.addr = a; r.sr = s; r.ck1 = k; r.x = x; r.c = c; r.idx = i; r.busy = b; r.done = d;
        return r;
    endfunction

    function automatic int oaddr(input logic b, input int k, input int by);
        return (int'(b) << (IW + 2)) + k * 4 + by;
    endfunction

    // Expected per-tick timeline of a whole scan, built object by object.
    task automatic gen_scan(input logic bk);
        snap_t s;
        logic [7:0] y, p, xx, cc;
        bit empty;
        int len;
        q.delete();
        s = exp_s;
        s.busy = 1'b1;
        s.done = 1'b0;
        for (int k = 0; k < NOBJ; k++) begin
            y  = mem[oaddr(bk, k, 0)];
            p  = mem[oaddr(bk, k, 1)];
            xx = mem[oaddr(bk, k, 2)];
            cc = mem[oaddr(bk, k, 3)];
`ifdef MO_SKIP_EMPTY_EN
            empty = (y == 8'h00);
`else
            empty = 1'b0;
`endif
            len = empty ? 5 : 7;
            s.idx = IW'(k);
            for (int t = 0; t < len; t++) begin
                s.addr = (IW + 3)'(oaddr(bk, k, (t > 3) ? 3 : t));
                if (t == 2) s.sr[15:8] = y;
                if (t == 3) s.sr[7:0] = p;
                if (t == 4) s.x = xx;
                if (t == 5) s.c = cc;
                s.ck1 = (t == 5);
                q.push_back(s);
            end
            s.c = cc;
        end
        s.ck1  = 1'b0;
        s.busy = 1'b0;
        s.done = 1'b1;
        q.push_back(s);
    endtask

    task automatic check(input string nm, input snap_t e);
        snap_t a;
        a = mk(ram_addr, SR, CK1, XPOS, COLOR, obj_idx, busy, done);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s @%0t: actual addr=%h sr=%h ck1=%b x=%h c=%h idx=%0d busy=%b done=%b required addr=%h sr=%h ck1=%b x=%h c=%h idx=%0d busy=%b done=%b",
                     nm, $time, a.addr, a.sr, a.ck1, a.x, a.c, a.idx, a.busy, a.done,
                     e.addr, e.sr, e.ck1, e.x, e.c, e.idx, e.busy, e.done);
        end
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: actual %0d required %0d", nm, act, expv);
        end
    endtask

    task automatic step(input logic ce, input logic ls, input logic bk, input string nm);
        ce2Hd5 = ce; line_start = ls; bank = bk;
        @(posedge clk);
        if (reset) begin
            exp_s = '0;
            q.delete();
        end else if (ce) begin
            if (ls) gen_scan(bk);
            if (q.size() > 0) exp_s = q.pop_front();
            else exp_s.done = 1'b0;
        end
        @(negedge clk);
        check(nm, exp_s);
    endtask

    task automatic run_to_done(input int start, input int expect_edges, input string nm);
        int e;
        bit seen;
        e = start; seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            step(1'b1, 1'b0, bank, nm);
            e++;
            if (done) seen = 1;
        end
        chk({nm, " done edge"}, seen ? e : -1, expect_edges);
    endtask

    task automatic fill_mem(input int zero_pct);
        for (int a = 0; a < 512; a++) begin
            if (a % 4 == 0)
                mem[a] = (int'($urandom_range(0, 99)) < zero_pct) ? 8'h00 : 8'($urandom_range(1, 255));
            else
                mem[a] = 8'($urandom);
        end
    endtask

    initial begin
        int first_ck, pulses, e, bad;
        bit seen;
        vectors = 0; miscompares = 0;
        exp_s = '0;
        reset = 1'b1; ce2Hd5 = 1'b0; line_start = 1'b0; bank = 1'b0;
        fill_mem(0);
        mem[9'h100] = 8'hE3; mem[9'h101] = 8'h12; mem[9'h102] = 8'h40; mem[9'h103] = 8'h05;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, mk(9'h000, 16'h0000, 1'b0, 8'h00, 8'h00, 6'd0, 1'b0, 1'b0)};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, mk(9'h000, 16'h0000, 1'b0, 8'h00, 8'h00, 6'd0, 1'b0, 1'b0)};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, mk(9'h100, 16'h0000, 1'b0, 8'h00, 8'h00, 6'd0, 1'b1, 1'b0)};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, mk(9'h100, 16'h0000, 1'b0, 8'h00, 8'h00, 6'd0, 1'b1, 1'b0)};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, mk(9'h101, 16'h0000, 1'b0, 8'h00, 8'h00, 6'd0, 1'b1, 1'b0)};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, mk(9'h102, 16'hE300, 1'b0, 8'h00, 8'h00, 6'd0, 1'b1, 1'b0)};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, mk(9'h102, 16'hE300, 1'b0, 8'h00, 8'h00, 6'd0, 1'b1, 1'b0)};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, mk(9'h103, 16'hE312, 1'b0, 8'h00, 8'h00, 6'd0, 1'b1, 1'b0)};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, mk(9'h103, 16'hE312, 1'b0, 8'h40, 8'h00, 6'd0, 1'b1, 1'b0)};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, mk(9'h103, 16'hE312, 1'b1, 8'h40, 8'h05, 6'd0, 1'b1, 1'b0)};
        tbl[10] = '{1'b0, 1'b0, 1'b0, mk(9'h103, 16'hE312, 1'b1, 8'h40, 8'h05, 6'd0, 1'b1, 1'b0)};
        tbl[11] = '{1'b1, 1'b0, 1'b0, mk(9'h103, 16'hE312, 1'b0, 8'h40, 8'h05, 6'd0, 1'b1, 1'b0)};
        tbl[12] = '{1'b1, 1'b0, 1'b0, mk(9'h104, 16'hE312, 1'b0, 8'h40, 8'h05, 6'd1, 1'b1, 1'b0)};

        // Reset, then a quiet idle stretch.
        step(1'b1, 1'b0, 1'b0, "reset");
        reset = 1'b0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, "idle");

        // First object fetch with interleaved disabled ticks.
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].ce, tbl[i].ls, tbl[i].bk, "table_model");
            check($sformatf("table row %0d", i), tbl[i].e);
        end
        run_to_done(7, 7 * NOBJ, "full_scan");
        step(1'b1, 1'b0, 1'b0, "post_done");
        chk("done one tick", int'(done), 0);
        chk("busy after done", int'(busy), 0);

        // Abort during object 17's EVAL.
        step(1'b1, 1'b1, 1'b0, "abort_start");
        for (int i = 0; i < 600 && !(obj_idx == 6'd17 && CK1); i++) step(1'b1, 1'b0, 1'b0, "abort_pre");
        chk("abort reach idx17 eval", int'(obj_idx == 6'd17 && CK1), 1);
        step(1'b1, 1'b1, 1'b1, "abort_restart");
        chk("abort ck1 low", int'(CK1), 0);
        chk("abort idx", int'(obj_idx), 0);
        chk("abort addr", int'(ram_addr), 'h100);
        chk("abort no done", int'(done), 0);
        run_to_done(0, 7 * NOBJ, "abort_rescan");

        // Bank flip mid-scan must not reach the address until the next start.
        step(1'b1, 1'b1, 1'b0, "flip_start");
        for (int i = 0; i < 600 && obj_idx != 6'd10; i++) step(1'b1, 1'b0, 1'b0, "flip_pre");
        chk("flip reach idx10", int'(obj_idx), 10);
        bad = 0;
        for (int i = 0; i < 600 && !done; i++) begin
            step(1'b1, 1'b0, 1'b1, "flip_run");
            if (ram_addr[IW+2] !== 1'b0) bad++;
        end
        chk("flip bank held", bad, 0);
        chk("flip scan done", int'(done), 1);
        step(1'b1, 1'b1, 1'b1, "flip_restart");
        chk("flip new bank", int'(ram_addr[IW+2]), 1);

        // Empty objects 0 and 2.
        mem[oaddr(1'b0, 0, 0)] = 8'h00;
        mem[oaddr(1'b0, 2, 0)] = 8'h00;
        step(1'b1, 1'b1, 1'b0, "skip_start");
        first_ck = -1; pulses = 0; e = 0; seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            step(1'b1, 1'b0, 1'b0, "skip_run");
            e++;
            if (CK1) begin
                pulses++;
                if (first_ck < 0) first_ck = e;
            end
            if (done) seen = 1;
        end
`ifdef MO_SKIP_EMPTY_EN
        chk("skip first ck1 edge", first_ck, 10);
        chk("skip ck1 pulses", pulses, NOBJ - 2);
        chk("skip done edge", seen ? e : -1, 7 * NOBJ - 4);
`else
        chk("noskip first ck1 edge", first_ck, 5);
        chk("noskip ck1 pulses", pulses, NOBJ);
        chk("noskip done edge", seen ? e : -1, 7 * NOBJ);
`endif

        // Randomized enables, starts, banks and RAM contents.
        fill_mem(25);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic ce, ls;
            if (cyc < 1000) ce = (cyc % 3 == 0);
            else if (cyc < 2000) ce = 1'($urandom);
            else ce = 1'b1;
            ls = (!busy && ($urandom % 20 == 0)) || ($urandom % 400 == 0);
            if (cyc == 1500) begin
                reset = 1'b1;
                step(1'b0, ls, 1'($urandom), "rand_reset");
                reset = 1'b0;
            end else begin
                step(ce, ls, 1'($urandom), "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
